branch_sequencer: RTL and testbench

Parametrised program-counter sequencer that replaces the fixed 4-flag, 16-bit branching unit. It accepts one control-flow request at a time through a valid/ready handshake. Each request is evaluated against a masked flag word under a selectable condition mode. The result updates the program counter by step, jump, call or return, and a bounded return-address stack tracks nested calls and flags overflow/underflow as a sticky fault.

---
 rtl/branch_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_branch_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: one control-flow request per three enabled cycles,
// conditional step/jump/call/return with a bounded return-address stack.
module branch_sequencer #(
    parameter int PC_WIDTH    = 16,
    parameter int FLAG_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               rx_enable,
    input  logic                               rx_valid,
    input  logic [1:0]                         rx_op,
    input  logic [1:0]                         rx_mode,
    input  logic [FLAG_WIDTH-1:0]              rx_check_flags,
    input  logic [FLAG_WIDTH-1:0]              rx_input_flags,
    input  logic [PC_WIDTH-1:0]                rx_target,
    input  logic                               rx_clear_fault,
    output logic                               tx_ready,
    output logic [PC_WIDTH-1:0]                tx_program_counter,
    output logic                               tx_valid,
    output logic                               tx_taken,
    output logic                               tx_fault,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   tx_stack_level
);

    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(STACK_DEPTH);

    localparam logic [1:0] OP_STEP   = 2'b00;
    localparam logic [1:0] OP_JUMP   = 2'b01;
    localparam logic [1:0] OP_CALL   = 2'b10;
    localparam logic [1:0] OP_RETURN = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EVAL   = 2'b01,
        COMMIT = 2'b10
    } state_t;

    state_t                 state_r, state_s;
    logic [1:0]             op_r, mode_r;
    logic [FLAG_WIDTH-1:0]  mask_r, flags_r;
    logic [PC_WIDTH-1:0]    target_r, pc_r;
    logic [PC_WIDTH-1:0]    stack_r [STACK_DEPTH];
    logic [LW-1:0]          level_r;
    logic                   valid_r, taken_r, fault_r;

    logic [PC_WIDTH-1:0]    next_pc_r;
    logic                   taken_eval_r, fault_eval_r, push_r, pop_r;

    logic                   accept_s, cond_s, taken_s, fault_s, push_s, pop_s;
    logic [PC_WIDTH-1:0]    pc_inc_s, next_pc_s, top_s;
    logic [IW-1:0]          top_idx_s, push_idx_s;

    function automatic logic eval_cond(input logic [1:0] mode,
                                       input logic [FLAG_WIDTH-1:0] mask,
                                       input logic [FLAG_WIDTH-1:0] flags);
        logic [FLAG_WIDTH-1:0] m;
        m = mask & flags;
        case (mode)
            2'b00:   return 1'b1;
            2'b01:   return |m;
            2'b10:   return (m == mask);
            2'b11:   return ~|m;
            default: return 1'b0;
        endcase
    endfunction

    assign accept_s   = rx_valid & rx_enable & (state_r == IDLE);
    assign pc_inc_s   = pc_r + PC_WIDTH'(1'b1);
    assign top_idx_s  = IW'(level_r - LW'(1'b1));
    assign push_idx_s = IW'(level_r);
    assign top_s      = stack_r[top_idx_s];

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; every transition waits for an enabled cycle
    always_comb begin
        state_s = state_r;
        if (rx_enable) begin
            case (state_r)
                IDLE:    if (rx_valid) state_s = EVAL; else state_s = IDLE;
                EVAL:    state_s = COMMIT;
                COMMIT:  state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Condition evaluation and PC/stack update decision for the latched request
    always_comb begin
        cond_s    = eval_cond(mode_r, mask_r, flags_r);
        next_pc_s = pc_inc_s;
        taken_s   = cond_s;
        fault_s   = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        case (op_r)
            OP_STEP: begin
                next_pc_s = pc_inc_s;
            end
            OP_JUMP: begin
                if (cond_s) next_pc_s = target_r; else next_pc_s = pc_inc_s;
            end
            OP_CALL: begin
                if (cond_s && (level_r != DEPTH_L)) begin
                    push_s    = 1'b1;
                    next_pc_s = target_r;
                end else if (cond_s) begin
                    fault_s = 1'b1;
                    taken_s = 1'b0;
                end else begin
                    taken_s = 1'b0;
                end
            end
            OP_RETURN: begin
                if (cond_s && (level_r != {LW{1'b0}})) begin
                    pop_s     = 1'b1;
                    next_pc_s = top_s;
                end else if (cond_s) begin
                    fault_s = 1'b1;
                    taken_s = 1'b0;
                end else begin
                    taken_s = 1'b0;
                end
            end
            default: begin
                next_pc_s = pc_inc_s;
            end
        endcase
    end

    // Request latch, evaluation pipeline register and committed outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            op_r         <= 2'b00;
            mode_r       <= 2'b00;
            mask_r       <= {FLAG_WIDTH{1'b0}};
            flags_r      <= {FLAG_WIDTH{1'b0}};
            target_r     <= {PC_WIDTH{1'b0}};
            next_pc_r    <= {PC_WIDTH{1'b0}};
            taken_eval_r <= 1'b0;
            fault_eval_r <= 1'b0;
            push_r       <= 1'b0;
            pop_r        <= 1'b0;
            pc_r         <= {PC_WIDTH{1'b0}};
            level_r      <= {LW{1'b0}};
            valid_r      <= 1'b0;
            taken_r      <= 1'b0;
            fault_r      <= 1'b0;
        end else if (rx_enable) begin
            if (accept_s) begin
                op_r     <= rx_op;
                mode_r   <= rx_mode;
                mask_r   <= rx_check_flags;
                flags_r  <= rx_input_flags;
                target_r <= rx_target;
            end
            if (state_r == EVAL) begin
                next_pc_r    <= next_pc_s;
                taken_eval_r <= taken_s;
                fault_eval_r <= fault_s;
                push_r       <= push_s;
                pop_r        <= pop_s;
            end
            if (state_r == COMMIT) begin
                pc_r    <= next_pc_r;
                taken_r <= taken_eval_r;
                if (push_r) level_r <= level_r + LW'(1'b1);
                if (pop_r)  level_r <= level_r - LW'(1'b1);
            end
            valid_r <= (state_r == COMMIT);
            // A fault raised by this commit outranks a simultaneous clear
            if ((state_r == COMMIT) && fault_eval_r) begin
                fault_r <= 1'b1;
            end else if (rx_clear_fault) begin
                fault_r <= 1'b0;
            end
        end
    end

    // Return-address storage; the push writes the address after the current PC
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {PC_WIDTH{1'b0}};
            end
        end else if (rx_enable && (state_r == COMMIT) && push_r) begin
            stack_r[push_idx_s] <= pc_inc_s;
        end
    end

    assign tx_ready           = (state_r == IDLE);
    assign tx_program_counter = pc_r;
    assign tx_valid           = valid_r;
    assign tx_taken           = taken_r;
    assign tx_fault           = fault_r;
    assign tx_stack_level     = level_r;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized and directed bench for branch_sequencer, checked every cycle
// against a transaction-level model of the sequencer.
module tb_branch_sequencer;

    localparam int PW = 16;
    localparam int FW = 8;
    localparam int SD = 4;
    localparam int LW = $clog2(SD + 1);

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          rx_enable = 1'b1;
    logic          rx_valid = 1'b0;
    logic [1:0]    rx_op = 2'b00;
    logic [1:0]    rx_mode = 2'b00;
    logic [FW-1:0] rx_check_flags = 8'h00;
    logic [FW-1:0] rx_input_flags = 8'h00;
    logic [PW-1:0] rx_target = 16'h0000;
    logic          rx_clear_fault = 1'b0;
    logic          tx_ready;
    logic [PW-1:0] tx_program_counter;
    logic          tx_valid;
    logic          tx_taken;
    logic          tx_fault;
    logic [LW-1:0] tx_stack_level;

    branch_sequencer #(.PC_WIDTH(PW), .FLAG_WIDTH(FW), .STACK_DEPTH(SD)) dut (
        .aclk(aclk), .aresetn(aresetn), .rx_enable(rx_enable), .rx_valid(rx_valid),
        .rx_op(rx_op), .rx_mode(rx_mode), .rx_check_flags(rx_check_flags),
        .rx_input_flags(rx_input_flags), .rx_target(rx_target),
        .rx_clear_fault(rx_clear_fault), .tx_ready(tx_ready),
        .tx_program_counter(tx_program_counter), .tx_valid(tx_valid),
        .tx_taken(tx_taken), .tx_fault(tx_fault), .tx_stack_level(tx_stack_level)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [15:0] m_pc = 16'h0000;
    logic        m_valid = 1'b0, m_taken = 1'b0, m_fault = 1'b0, m_c;
    logic [15:0] m_stk[$];
    int          m_busy = 0;   // enabled cycles elapsed since the request was accepted
    logic [1:0]  q_op, q_mode;
    logic [7:0]  q_mask, q_flags;
    logic [15:0] q_tgt;

    function automatic logic m_cond(input logic [1:0] mode, input logic [7:0] mask, input logic [7:0] flags);
        if (mode == 2'd0) return 1'b1;
        if (mode == 2'd1) return (flags & mask) != 8'h00;
        if (mode == 2'd2) return (flags & mask) == mask;
        return (flags & mask) == 8'h00;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_pc = 16'h0000; m_valid = 1'b0; m_taken = 1'b0; m_fault = 1'b0;
            m_stk.delete(); m_busy = 0;
        end else if (rx_enable) begin
            if (rx_clear_fault) m_fault = 1'b0;
            m_valid = 1'b0;
            if (m_busy == 2) begin
                m_c = m_cond(q_mode, q_mask, q_flags);
                m_valid = 1'b1;
                m_busy = 0;
                case (q_op)
                    2'd0: begin m_pc = m_pc + 16'd1; m_taken = m_c; end
                    2'd1: begin m_pc = m_c ? q_tgt : m_pc + 16'd1; m_taken = m_c; end
                    2'd2: begin
                        if (!m_c) begin m_pc = m_pc + 16'd1; m_taken = 1'b0; end
                        else if (m_stk.size() < SD) begin
                            m_stk.push_back(m_pc + 16'd1); m_pc = q_tgt; m_taken = 1'b1;
                        end else begin m_pc = m_pc + 16'd1; m_fault = 1'b1; m_taken = 1'b0; end
                    end
                    default: begin
                        if (!m_c) begin m_pc = m_pc + 16'd1; m_taken = 1'b0; end
                        else if (m_stk.size() > 0) begin m_pc = m_stk.pop_back(); m_taken = 1'b1; end
                        else begin m_pc = m_pc + 16'd1; m_fault = 1'b1; m_taken = 1'b0; end
                    end
                endcase
            end else if (m_busy == 1) begin
                m_busy = 2;
            end else if (rx_valid) begin
                q_op = rx_op; q_mode = rx_mode; q_mask = rx_check_flags;
                q_flags = rx_input_flags; q_tgt = rx_target;
                m_busy = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic cmp_en = 1'b0;
    always @(negedge aclk) begin
        if (cmp_en) begin
            check("ready", tx_ready, m_busy == 0);
            check("pc", tx_program_counter, m_pc);
            check("valid", tx_valid, m_valid);
            check("taken", tx_taken, m_taken);
            check("fault", tx_fault, m_fault);
            check("level", tx_stack_level, m_stk.size());
        end
    end

    int   cyc = 0;
    int   pulse_cyc[$];
    logic prev_v = 1'b0;
    always @(negedge aclk) begin
        cyc++;
        if (tx_valid && !prev_v) pulse_cyc.push_back(cyc);
        prev_v = tx_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic scramble();
        rx_op = 2'($urandom); rx_mode = 2'($urandom);
        rx_check_flags = 8'($urandom); rx_input_flags = 8'($urandom);
        rx_target = 16'($urandom);
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] mode, input logic [7:0] mask,
                         input logic [7:0] flags, input logic [15:0] tgt);
        int g;
        g = 0;
        while (!tx_ready && g < 50) begin @(posedge aclk); #2; g++; end
        if (g >= 50) check("ready_timeout", 32'd0, 32'd1);
        rx_valid = 1'b1; rx_op = op; rx_mode = mode;
        rx_check_flags = mask; rx_input_flags = flags; rx_target = tgt;
        @(posedge aclk); #2;
        scramble();
        g = 0;
        while (!tx_valid && g < 50) begin
            rx_valid = 1'($urandom);
            @(posedge aclk); #2; g++;
        end
        rx_valid = 1'b0;
        if (g >= 50) check("commit_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_fault();
        rx_clear_fault = 1'b1;
        @(posedge aclk); #2;
        rx_clear_fault = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        cmp_en = 1'b1;
        check("rst_pc", tx_program_counter, 32'h0);
        check("rst_ready", tx_ready, 32'h1);
        check("rst_valid", tx_valid, 32'h0);
        check("rst_level", tx_stack_level, 32'h0);
        check("rst_fault", tx_fault, 32'h0);

        // three back-to-back steps
        pulse_cyc.delete();
        issue(2'd0, 2'd0, 8'h00, 8'h00, 16'h0000); check("step1_pc", tx_program_counter, 32'h1);
        issue(2'd0, 2'd0, 8'h00, 8'h00, 16'h0000); check("step2_pc", tx_program_counter, 32'h2);
        issue(2'd0, 2'd0, 8'h00, 8'h00, 16'h0000); check("step3_pc", tx_program_counter, 32'h3);
        @(posedge aclk); #2;
        check("step_pulses", pulse_cyc.size(), 32'd3);
        if (pulse_cyc.size() == 3) begin
            check("step_gap1", pulse_cyc[1] - pulse_cyc[0], 32'd3);
            check("step_gap2", pulse_cyc[2] - pulse_cyc[1], 32'd3);
        end

        // conditional jumps
        issue(2'd1, 2'd1, 8'h0C, 8'h04, 16'h1234);
        check("jany_pc", tx_program_counter, 32'h1234); check("jany_taken", tx_taken, 32'h1);
        issue(2'd1, 2'd1, 8'h0C, 8'h03, 16'h1234);
        check("jany_nt_pc", tx_program_counter, 32'h1235); check("jany_nt_taken", tx_taken, 32'h0);
        issue(2'd1, 2'd2, 8'h0C, 8'h04, 16'h0999);
        check("jall_nt_pc", tx_program_counter, 32'h1236); check("jall_nt_taken", tx_taken, 32'h0);
        issue(2'd1, 2'd2, 8'h00, 8'hA5, 16'h0040);
        check("jall_m0_pc", tx_program_counter, 32'h0040); check("jall_m0_taken", tx_taken, 32'h1);
        issue(2'd1, 2'd1, 8'h00, 8'hFF, 16'h0777);
        check("jany_m0_pc", tx_program_counter, 32'h0041);
        issue(2'd1, 2'd3, 8'h00, 8'hFF, 16'h0010);
        check("jnone_m0_pc", tx_program_counter, 32'h0010);

        // nested calls and returns
        issue(2'd2, 2'd0, 8'h00, 8'h00, 16'h0100);
        issue(2'd2, 2'd0, 8'h00, 8'h00, 16'h0100);
        check("call2_pc", tx_program_counter, 32'h0100); check("call2_lvl", tx_stack_level, 32'd2);
        issue(2'd3, 2'd0, 8'h00, 8'h00, 16'h0000); check("ret1_pc", tx_program_counter, 32'h0101);
        issue(2'd3, 2'd0, 8'h00, 8'h00, 16'h0000); check("ret2_pc", tx_program_counter, 32'h0011);
        check("ret2_lvl", tx_stack_level, 32'd0);

        // overflow, underflow, fault clear
        for (int i = 0; i < SD; i++) issue(2'd2, 2'd0, 8'h00, 8'h00, 16'h0200);
        check("full_lvl", tx_stack_level, 32'd4); check("full_fault", tx_fault, 32'h0);
        issue(2'd2, 2'd0, 8'h00, 8'h00, 16'h0200);
        check("ovf_pc", tx_program_counter, 32'h0201); check("ovf_fault", tx_fault, 32'h1);
        check("ovf_taken", tx_taken, 32'h0); check("ovf_lvl", tx_stack_level, 32'd4);
        clear_fault();
        check("clr_fault", tx_fault, 32'h0);
        for (int i = 0; i < SD; i++) issue(2'd3, 2'd0, 8'h00, 8'h00, 16'h0000);
        check("pop_all_pc", tx_program_counter, 32'h0012);
        issue(2'd3, 2'd0, 8'h00, 8'h00, 16'h0000);
        check("udf_pc", tx_program_counter, 32'h0013); check("udf_fault", tx_fault, 32'h1);
        check("udf_taken", tx_taken, 32'h0);
        clear_fault();

        // wrap
        issue(2'd1, 2'd0, 8'h00, 8'h00, 16'hFFFF);
        issue(2'd0, 2'd0, 8'h00, 8'h00, 16'h0000);
        check("wrap_pc", tx_program_counter, 32'h0000);

        // stall during EVAL, then stretch the valid pulse
        rx_valid = 1'b1; rx_op = 2'd0; rx_mode = 2'd0;
        @(posedge aclk); #2;
        rx_valid = 1'b0; rx_enable = 1'b0;
        n = 0;
        repeat (5) begin @(posedge aclk); #2; n++; end
        rx_enable = 1'b1;
        while (!tx_valid && n < 60) begin @(posedge aclk); #2; n++; end
        check("stall_latency", n, 32'd7);
        check("stall_pc", tx_program_counter, 32'h0001);
        rx_enable = 1'b0;
        repeat (3) begin @(posedge aclk); #2; check("stretch_valid", tx_valid, 32'h1); end
        rx_enable = 1'b1;
        @(posedge aclk); #2;
        check("stretch_end", tx_valid, 32'h0);

        // reset in the middle of a commit
        issue(2'd2, 2'd0, 8'h00, 8'h00, 16'h0300);
        check("pre_rst_lvl", tx_stack_level, 32'd1);
        rx_valid = 1'b1; rx_op = 2'd2; rx_mode = 2'd0; rx_target = 16'h0400;
        @(posedge aclk); #2;
        rx_valid = 1'b0;
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_pc", tx_program_counter, 32'h0);
        check("mid_rst_lvl", tx_stack_level, 32'h0);
        check("mid_rst_ready", tx_ready, 32'h1);
        @(posedge aclk); #2;
        aresetn = 1'b1;
        @(posedge aclk); #2;
        check("post_rst_valid", tx_valid, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rx_enable = ($urandom_range(0, 9) != 0);
            rx_valid = ($urandom_range(0, 2) != 0);
            rx_op = 2'($urandom);
            rx_mode = 2'($urandom);
            rx_check_flags = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rx_input_flags = 8'($urandom);
            rx_target = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rx_clear_fault = ($urandom_range(0, 15) == 0);
            if (i == 1500) aresetn = 1'b0;
            if (i == 1502) aresetn = 1'b1;
            @(posedge aclk); #2;
        end
        rx_valid = 1'b0;
        rx_enable = 1'b1;
        repeat (4) @(posedge aclk);
        #2;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
